// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Build option: SEQ_TX_PARITY_EN adds a trailing even-parity bit.
package seq_pattern_tx_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_SHIFT = 2'b01
`ifdef SEQ_TX_PARITY_EN
    ,
    SEQ_PAR   = 2'b10
`endif
  } seq_state_e;

  // Pattern looked for by the downstream detector.
  localparam logic [2:0] DET_PATTERN_101 = 3'b101;

endpackage

// File: rtl/seq_pattern_tx_bit_cnt.sv
// Loadable down-counter that tracks the remaining pattern bits.
// Build option: none (SEQ_TX_PARITY_EN is handled in the top).
module seq_bit_cnt #(
  parameter int LENW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [LENW-1:0] len_i,
  input  logic            dec_i,
  output logic            last_o
);

  logic [LENW-1:0] cnt_q;
  logic [LENW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - LENW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LENW'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// MSB-first serial pattern transmitter with valid/ready load port.
// Build option: SEQ_TX_PARITY_EN appends one even-parity bit.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LENW-1:0]  load_len,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             seq_out_q, seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;

  logic [LENW-1:0]  len_c;
  logic [LENW-1:0]  shamt;
  logic [WIDTH-1:0] aligned;

`ifdef SEQ_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Left-justify the pattern so bit len-1 sits at the MSB.
  assign len_c   = (load_len > LENW'(WIDTH)) ? LENW'(WIDTH)
                                             : load_len;
  assign shamt   = LENW'(WIDTH) - len_c;
  assign aligned = load_data << shamt;

  seq_bit_cnt #(
    .LENW (LENW)
  ) u_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (cnt_load),
    .len_i  (len_c),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      SEQ_IDLE: begin
        if (load_valid) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = SEQ_SHIFT;
            seq_out_d   = aligned[WIDTH-1];
            seq_valid_d = 1'b1;
            shreg_d     = aligned << 1;
            cnt_load    = 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par_d       = aligned[WIDTH-1];
`endif
          end
        end
      end
      SEQ_SHIFT: begin
        if (cnt_last) begin
`ifdef SEQ_TX_PARITY_EN
          state_d     = SEQ_PAR;
          seq_out_d   = par_q;
          seq_valid_d = 1'b1;
`else
          state_d     = SEQ_IDLE;
          done_d      = 1'b1;
`endif
        end else begin
          seq_out_d   = shreg_q[WIDTH-1];
          seq_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          cnt_dec     = 1'b1;
`ifdef SEQ_TX_PARITY_EN
          par_d       = par_q ^ shreg_q[WIDTH-1];
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      SEQ_PAR: begin
        state_d = SEQ_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      shreg_q     <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      done_q      <= done_d;
`ifdef SEQ_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign load_ready = (state_q == SEQ_IDLE);
  assign seq_out    = seq_out_q;
  assign seq_valid  = seq_valid_q;
  assign done       = done_q;

endmodule
